frame_rx_saw: RTL and testbench

FRAME_RX_SAW -- requirements
Module: frame_rx_saw

---
 rtl/frame_rx_saw.sv | 135 +++++++++++++
 tb/tb_frame_rx_saw.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/frame_rx_saw.sv
// Stop-and-wait frame receiver: bit-serial CRC check, in-order delivery, ACK/NAK response.
// Optional FRAME_RX_SAW_NAK_EN: bad-CRC frames are answered with a NAK instead of being dropped.
module frame_rx_saw #(
  parameter int              BW   = 10,
  parameter int              CW   = 4,
  parameter logic [CW-1:0]   POLY = 4'b0011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [BW-1:0]    in_frame,
  output logic             in_ready,
  output logic             out_valid,
  output logic [BW-2-CW:0] out_data,
  output logic             ack_valid,
  output logic             ack_seq,
  output logic             ack_nak,
  input  logic             ack_ready
);

  localparam int MW   = BW - CW;          // bits covered by the CRC: seq + payload
  localparam int CNTW = $clog2(MW + 1);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     frame_q;
  logic [MW-1:0]     msg_q;               // shifts left so the next CRC input bit is always the MSB
  logic [CW-1:0]     crc_q;
  logic [CNTW-1:0]   cnt_q;
  logic              exp_seq_q;
  logic              out_valid_q;
  logic [BW-2-CW:0]  out_data_q;
  logic              ack_valid_q, ack_seq_q, ack_nak_q;

  logic              fb, crc_ok, last_bit;
  logic [CW-1:0]     crc_step;
  logic              accept, deliver, respond, nak, ack_done;

  assign fb       = msg_q[MW-1] ^ crc_q[CW-1];
  assign crc_step = {crc_q[CW-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign crc_ok   = (crc_q == frame_q[CW-1:0]);
  assign last_bit = (cnt_q == CNTW'(MW));

  // NOTE: every signal driven here gets a default first so no path can leave one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    deliver  = 1'b0;
    respond  = 1'b0;
    nak      = 1'b0;
    ack_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CHECK;
          accept  = 1'b1;
        end
      end
      CHECK: begin
        if (last_bit) begin
          if (crc_ok) begin
            state_d = RESP;
            respond = 1'b1;
            deliver = (frame_q[BW-1] == exp_seq_q);
          end else begin
`ifdef FRAME_RX_SAW_NAK_EN
            state_d = RESP;
            respond = 1'b1;
            nak     = 1'b1;
`else
            state_d = IDLE;
`endif
          end
        end
      end
      RESP: begin
        if (ack_ready) begin
          state_d  = IDLE;
          ack_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      msg_q       <= '0;
      crc_q       <= '0;
      cnt_q       <= '0;
      exp_seq_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ack_valid_q <= 1'b0;
      ack_seq_q   <= 1'b0;
      ack_nak_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= deliver;
      if (accept) begin
        frame_q <= in_frame;
        msg_q   <= in_frame[BW-1:CW];
        crc_q   <= '0;
        cnt_q   <= '0;
      end else if (state_q == CHECK && !last_bit) begin
        crc_q <= crc_step;
        msg_q <= msg_q << 1;
        cnt_q <= cnt_q + 1'b1;
      end
      if (deliver) begin
        out_data_q <= frame_q[BW-2:CW];
        exp_seq_q  <= ~exp_seq_q;
      end
      if (respond) begin
        ack_valid_q <= 1'b1;
        ack_seq_q   <= nak ? exp_seq_q : frame_q[BW-1];
        ack_nak_q   <= nak;
      end else if (ack_done) begin
        ack_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ack_valid = ack_valid_q;
  assign ack_seq   = ack_seq_q;
  assign ack_nak   = ack_nak_q;

endmodule

// File: tb/tb_frame_rx_saw.sv
// Randomized scoreboard bench for frame_rx_saw; the reference model uses CRC polynomial long division.
module tb_frame_rx_saw;

  localparam int BW = 10;
  localparam int CW = 4;
  localparam int PW = BW - 1 - CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_frame = '0;
  logic          in_ready;
  logic          out_valid;
  logic [PW-1:0] out_data;
  logic          ack_valid, ack_seq, ack_nak;
  logic          ack_ready = 1'b0;

  int passed = 0;
  int total  = 0;
  logic model_seq = 1'b0;
  logic [PW-1:0] dq[$];
  logic [1:0]    aq[$];   // {seq, nak}
  logic          ack_prev = 1'b0;

  frame_rx_saw dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_frame(in_frame), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .ack_valid(ack_valid), .ack_seq(ack_seq),
    .ack_nak(ack_nak), .ack_ready(ack_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Remainder of (msg * x^4) divided by x^4+x+1.
  function automatic logic [CW-1:0] crc_ref(input logic [BW-CW-1:0] msg);
    int rem = int'(msg) << CW;
    for (int i = BW - 1; i >= CW; i--)
      if (rem[i]) rem = rem ^ (32'h13 << (i - CW));
    return rem[CW-1:0];
  endfunction

  // Monitor: pops expectations whenever the DUT presents a delivery or a new response.
  always @(negedge clk) begin
    if (rst) begin
      ack_prev <= 1'b0;
    end else begin
      if (out_valid) begin
        if (dq.size() == 0) check("unexpected_out_valid", 1, 0);
        else check("out_data", 32'(out_data), 32'(dq.pop_front()));
      end
      if (ack_valid && !ack_prev) begin
        if (aq.size() == 0) check("unexpected_ack", 1, 0);
        else check("ack_seq_nak", 32'({ack_seq, ack_nak}), 32'(aq.pop_front()));
      end
      ack_prev <= ack_valid;
    end
  end

  task automatic send(input logic [BW-1:0] f, input bit abort, input int stall);
    logic good, seq, resp, s0, n0, seen;
    int n;
    seq  = f[BW-1];
    good = (crc_ref(f[BW-1:CW]) == f[CW-1:0]);
    in_valid = 1'b1;
    in_frame = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_low_after_accept", 32'(in_ready), 0);
    if (abort) begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_seq = 1'b0;
      check("abort_in_ready", 32'(in_ready), 1);
      check("abort_outputs", 32'({out_valid, ack_valid, ack_seq, ack_nak, out_data}), 0);
      return;
    end
    resp = 1'b1;
    if (good && seq == model_seq) begin
      dq.push_back(f[BW-2:CW]);
      aq.push_back({seq, 1'b0});
      model_seq = ~model_seq;
    end else if (good) begin
      aq.push_back({seq, 1'b0});
    end else begin
`ifdef FRAME_RX_SAW_NAK_EN
      aq.push_back({model_seq, 1'b1});
`else
      resp = 1'b0;
`endif
    end
    n = 0;
    seen = 1'b0;
    while (n < 30 && !seen) begin
      ack_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
      seen = ack_valid || in_ready;
    end
    ack_ready = 1'b0;
    check("latency", 32'(n), 7);
    if (!resp) begin
      check("bad_crc_idle", 32'({in_ready, ack_valid, out_valid}), 32'b100);
      return;
    end
    check("resp_state", 32'({in_ready, ack_valid}), 32'b01);
    s0 = ack_seq;
    n0 = ack_nak;
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_frame = BW'($urandom);
      @(posedge clk); #1;
      check("stall_hold", 32'({in_ready, ack_valid, ack_seq, ack_nak}), 32'({1'b0, 1'b1, s0, n0}));
    end
    in_valid  = 1'b0;
    ack_ready = 1'b1;
    @(posedge clk); #1;
    ack_ready = 1'b0;
    check("handshake_idle", 32'({in_ready, ack_valid}), 32'b10);
  endtask

  initial begin
    logic [BW-1:0] f;
    logic [PW-1:0] pl;
    logic s;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_outputs", 32'({out_valid, ack_valid, ack_seq, ack_nak, out_data}), 0);

    send(10'h013, 0, 0);
    send(10'h20A, 0, 0);
    send(10'h20A, 0, 0);
    send(10'h012, 0, 0);
    send(10'h013, 0, 5);
    send(10'h013, 1, 0);
    send(10'h013, 0, 1);

    for (int i = 0; i < 40; i++) begin
      pl = PW'($urandom);
      s  = ($urandom_range(0, 9) < 7) ? model_seq : ~model_seq;
      f  = {s, pl, crc_ref({s, pl})};
      if ($urandom_range(0, 3) == 0) f[CW-1:0] = f[CW-1:0] ^ CW'($urandom_range(1, 15));
      send(f, 0, $urandom_range(0, 3));
      ack_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 ack_ready = 1'b0;
    end

    repeat (5) @(posedge clk);
    check("delivery_queue_drained", 32'(dq.size()), 0);
    check("ack_queue_drained", 32'(aq.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
